// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared datapath constants and the fetch-stage state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int               XLEN             = 32;
  localparam logic [XLEN-1:0]  RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0]  NOP_INSTR        = 32'h0000_0000;

  // RUN: flowing; STALL_EMPTY: held, nothing parked; STALL_FULL: held, one return parked
  typedef enum logic [1:0] {
    RUN         = 2'd0,
    STALL_EMPTY = 2'd1,
    STALL_FULL  = 2'd2
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_skid_buf
// Description : One-entry {pc, instr} holding register that parks an
//               instruction returning from memory while the stage is stalled.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid_buf #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            load,
  input  logic            drain,
  input  logic [XLEN-1:0] load_pc,
  input  logic [XLEN-1:0] load_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;

  // Next entry contents: clear beats load, load beats drain
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = load_pc;
      instr_d = load_instr;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  // Entry storage
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid = valid_q;
  assign pc    = pc_q;
  assign instr = instr_q;

endmodule
`default_nettype wire

// File: rtl/pc_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_stage
// Description : Instruction-fetch front end. Owns the PC, issues word reads
//               to a 1-cycle synchronous instruction memory and fills the
//               IF/ID register, with a one-entry skid for stall overlap.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_stage #(
  parameter int              XLEN     = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC_DEFAULT,
  parameter int unsigned     PC_STEP  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_en,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  output logic [31:0]     fetch_count
);

  import cpu_pkg::*;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            req_valid_q, req_valid_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [XLEN-1:0] if_instr_q, if_instr_d;
  logic [31:0]     fetch_count_q, fetch_count_d;
  fetch_state_e    state_q, state_d;

  logic            skid_load, skid_drain, skid_clear, skid_valid;
  logic [XLEN-1:0] skid_pc, skid_instr;

  // A read issues only when nothing is holding or steering the front end
  assign imem_en   = !rst && !redirect_valid && !stall;
  assign imem_addr = pc_q;

  // Next PC and in-flight request tracking; a redirect drops the in-flight read
  always_comb begin
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    req_valid_d = imem_en;
    if (redirect_valid) begin
      pc_d        = redirect_target;
      req_valid_d = 1'b0;
    end else if (imem_en) begin
      pc_d     = pc_q + XLEN'(PC_STEP);
      req_pc_d = pc_q;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // FSM next state: redirect always returns to RUN
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN, STALL_EMPTY: begin
          if (stall) state_d = req_valid_q ? STALL_FULL : STALL_EMPTY;
          else       state_d = RUN;
        end
        STALL_FULL: if (!stall) state_d = RUN;
        default:    state_d = RUN;
      endcase
    end
  end

  // FSM outputs: IF/ID load source, skid control and the accept counter
  always_comb begin
    if_valid_d    = if_valid_q;
    if_pc_d       = if_pc_q;
    if_instr_d    = if_instr_q;
    fetch_count_d = fetch_count_q;
    skid_load     = 1'b0;
    skid_drain    = 1'b0;
    skid_clear    = 1'b0;
    if (redirect_valid) begin
      if_valid_d = 1'b0;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        RUN, STALL_EMPTY: begin
          if (stall) begin
            // Last return after stall asserts parks in the skid
            skid_load = req_valid_q;
          end else if (req_valid_q) begin
            if_valid_d    = 1'b1;
            if_pc_d       = req_pc_q;
            if_instr_d    = imem_rdata;
            fetch_count_d = fetch_count_q + 32'd1;
          end else begin
            if_valid_d = 1'b0;
          end
        end
        STALL_FULL: begin
          if (!stall && skid_valid) begin
            if_valid_d    = 1'b1;
            if_pc_d       = skid_pc;
            if_instr_d    = skid_instr;
            fetch_count_d = fetch_count_q + 32'd1;
            skid_drain    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // PC, in-flight and IF/ID registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      req_valid_q   <= 1'b0;
      req_pc_q      <= '0;
      if_valid_q    <= 1'b0;
      if_pc_q       <= '0;
      if_instr_q    <= NOP_INSTR;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      req_valid_q   <= req_valid_d;
      req_pc_q      <= req_pc_d;
      if_valid_q    <= if_valid_d;
      if_pc_q       <= if_pc_d;
      if_instr_q    <= if_instr_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  fetch_skid_buf #(
    .XLEN (XLEN)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .clear      (skid_clear),
    .load       (skid_load),
    .drain      (skid_drain),
    .load_pc    (req_pc_q),
    .load_instr (imem_rdata),
    .valid      (skid_valid),
    .pc         (skid_pc),
    .instr      (skid_instr)
  );

  assign if_valid    = if_valid_q;
  assign if_pc       = if_pc_q;
  assign if_instr    = if_instr_q;
  assign fetch_count = fetch_count_q;

endmodule
`default_nettype wire
